pipe_stage_skid: RTL and testbench
==================================

PIPE_STAGE_SKID -- requirements
Module: pipe_stage_skid

Interface
- REQ-001: Parameter PC_W, default 16, SHALL set the width of both PC fields.
- REQ-002: Parameter INSTR_W, default 16, SHALL set the instruction width.
- REQ-003: Parameter NOP_INSTR, default 16'h0800, SHALL set the INSTR_W-bit encoding driven when no valid entry is presented.
- REQ-004: clk  input  1  single clock; all state SHALL update on its rising edge.
- REQ-005: rst_n  input  1  asynchronous reset, active-low.
- REQ-006: flush  input  1  synchronous flush; empties the stage.
- REQ-007: in_valid  input  1  upstream (fetch) presents an entry.
- REQ-008: in_ready  output  1  stage can accept; driven directly from a flop.
- REQ-009: in_pc  input  PC_W  fetch PC without +2.
- REQ-010: in_pc_plus2  input  PC_W  fetch PC+2.
- REQ-011: in_instr  input  INSTR_W  fetched instruction.
- REQ-012: out_valid  output  1  entry presented to decode.
- REQ-013: out_ready  input  1  decode consumes the entry this cycle.
- REQ-014: out_pc, out_pc_plus2, out_instr  output  PC_W/PC_W/INSTR_W  presented entry.
- REQ-015: occupancy  output  2  number of held entries, 0..2.

Function
- REQ-016: accept = in_valid & in_ready; emit = out_valid & out_ready; an entry SHALL be the tuple {pc, pc_plus2, instr}.
- REQ-017: Storage SHALL be two slots: MAIN (drives out_*) and SKID; state SHALL be EMPTY (0), HALF (1) or FULL (2), equal to occupancy.
- REQ-018: EMPTY: accept -> HALF with MAIN<=input; otherwise remain EMPTY.
- REQ-019: HALF: accept & !emit -> FULL with SKID<=input; emit & !accept -> EMPTY; accept & emit -> HALF with MAIN<=input; neither -> HALF, hold.
- REQ-020: FULL: emit -> HALF with MAIN<=SKID; no emit -> hold; accept SHALL NOT occur (in_ready=0).
- REQ-021: out_valid SHALL be 1 exactly when state != EMPTY.
- REQ-022: When out_valid=0, out_instr SHALL equal NOP_INSTR and out_pc/out_pc_plus2 SHALL equal 0.
- REQ-023: in_ready (registered) SHALL equal 1 in the cycle after any edge whose next state is EMPTY or HALF, and 0 after any edge whose next state is FULL.
- REQ-024: Latency SHALL be one cycle: an entry accepted at edge N into EMPTY SHALL appear on out_* after edge N.
- REQ-025: Sustained throughput SHALL be one entry per cycle when out_ready=1 continuously.
- REQ-026: While out_valid=1 and out_ready=0, out_* SHALL remain stable.
- REQ-027: Entries SHALL exit in acceptance order; none SHALL be dropped or duplicated except by flush.
- REQ-028: flush=1 SHALL have highest priority: next state EMPTY, both slots invalidated, any same-cycle input accept discarded.
- REQ-029: An emit in the flush cycle SHALL count as consumed (decode owns it); no entry SHALL be presented in the following cycle.
- REQ-030: in_ready SHALL be 1 the cycle after a flush.

Reset
- REQ-031: rst_n=0 SHALL immediately, without a clock, force state EMPTY, occupancy=0, out_valid=0, in_ready=0, out_instr=NOP_INSTR, out_pc=0, out_pc_plus2=0.
- REQ-032: After rst_n deasserts, in_ready SHALL rise at the first rising clk edge; no accept SHALL occur before that edge.
- REQ-033: Reset asserted mid-operation SHALL discard all held entries with no partial update.

Verification
- REQ-034: Reset release, in_valid=1 pc=0x0010 instr=0x1234, out_ready=1 -> in_ready=1 after edge 1; out_valid=1, out_instr=0x1234, out_pc_plus2=0x0012 after edge 2.
- REQ-035: out_ready=0, three back-to-back inputs A, B, C -> A on out, occupancy=2, in_ready=0, C held off; raise out_ready -> A, B, C exit in order, with no loss.
- REQ-036: Streaming 8 entries with out_ready=1 -> 8 outputs on 8 consecutive cycles, occupancy stays 1, in_ready stays 1.
- REQ-037: FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, out_instr=0x0800, occupancy=0, in_ready=1; the input is not emitted.
- REQ-038: rst_n pulsed low asynchronously while FULL -> outputs go to reset values before the next edge; entries are never emitted.
- REQ-039: PC_W=32, INSTR_W=32, NOP_INSTR=32'h0 -> scenarios REQ-034 to REQ-037 pass with full-width values, e.g. pc=0xFFFF_FFFE.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Fetch-to-decode pipeline register with a one-entry skid buffer.
// in_ready comes straight from a flop, so the skid slot absorbs the entry already in flight when decode stalls.
module pipe_stage_skid #(
  parameter int                 PC_W      = 16,
  parameter int                 INSTR_W   = 16,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 16'h0800
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [PC_W-1:0]    in_pc_plus2,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [PC_W-1:0]    out_pc_plus2,
  output logic [INSTR_W-1:0] out_instr,
  output logic [1:0]         occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               inReady_q, inReady_d;
  logic [PC_W-1:0]    mainPc_q, mainPc_d;
  logic [PC_W-1:0]    mainPcP2_q, mainPcP2_d;
  logic [INSTR_W-1:0] mainInstr_q, mainInstr_d;
  logic [PC_W-1:0]    skidPc_q, skidPc_d;
  logic [PC_W-1:0]    skidPcP2_q, skidPcP2_d;
  logic [INSTR_W-1:0] skidInstr_q, skidInstr_d;
  logic               accept;
  logic               emit;

  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & inReady_q;
  assign emit      = out_valid & out_ready;

  always_comb begin
    state_d     = state_q;
    mainPc_d    = mainPc_q;
    mainPcP2_d  = mainPcP2_q;
    mainInstr_d = mainInstr_q;
    skidPc_d    = skidPc_q;
    skidPcP2_d  = skidPcP2_q;
    skidInstr_d = skidInstr_q;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d     = HALF;
          mainPc_d    = in_pc;
          mainPcP2_d  = in_pc_plus2;
          mainInstr_d = in_instr;
        end
      end
      HALF: begin
        if (accept && !emit) begin
          state_d     = FULL;
          skidPc_d    = in_pc;
          skidPcP2_d  = in_pc_plus2;
          skidInstr_d = in_instr;
        end else if (emit && !accept) begin
          state_d = EMPTY;
        end else if (accept && emit) begin
          mainPc_d    = in_pc;
          mainPcP2_d  = in_pc_plus2;
          mainInstr_d = in_instr;
        end
      end
      FULL: begin
        if (emit) begin
          state_d     = HALF;
          mainPc_d    = skidPc_q;
          mainPcP2_d  = skidPcP2_q;
          mainInstr_d = skidInstr_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    // Flush wins over everything; slot contents become don't-care once the state is EMPTY.
    if (flush) begin
      state_d = EMPTY;
    end

    inReady_d = (state_d != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      inReady_q   <= 1'b0;
      mainPc_q    <= '0;
      mainPcP2_q  <= '0;
      mainInstr_q <= NOP_INSTR;
      skidPc_q    <= '0;
      skidPcP2_q  <= '0;
      skidInstr_q <= NOP_INSTR;
    end else begin
      state_q     <= state_d;
      inReady_q   <= inReady_d;
      mainPc_q    <= mainPc_d;
      mainPcP2_q  <= mainPcP2_d;
      mainInstr_q <= mainInstr_d;
      skidPc_q    <= skidPc_d;
      skidPcP2_q  <= skidPcP2_d;
      skidInstr_q <= skidInstr_d;
    end
  end

  assign in_ready     = inReady_q;
  assign occupancy    = state_q;
  assign out_pc       = out_valid ? mainPc_q    : '0;
  assign out_pc_plus2 = out_valid ? mainPcP2_q  : '0;
  assign out_instr    = out_valid ? mainInstr_q : NOP_INSTR;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: vector table, hand sequences for stall/flush/reset, and an in-order scoreboard.
// A second 32-bit instance covers wide PCs/instructions and a zero NOP encoding.
module tb_pipe_stage_skid;

  localparam logic [15:0] NOP16 = 16'h0800;

  logic        clk = 1'b0;
  logic        rstN;
  logic        flush, inValid, inReady, outValid, outReady;
  logic [15:0] inPc, inPcP2, inInstr, outPc, outPcP2, outInstr;
  logic [1:0]  occ;

  logic        wFlush, wInValid, wInReady, wOutValid, wOutReady;
  logic [31:0] wInPc, wInPcP2, wInInstr, wOutPc, wOutPcP2, wOutInstr;
  logic [1:0]  wOcc;

  int compared   = 0;
  int mismatched = 0;
  int emitCount  = 0;
  int emitStart;

  typedef struct {
    logic [15:0] pc;
    logic [15:0] pcP2;
    logic [15:0] instr;
  } sb_t;
  sb_t sbQ[$];

  typedef struct {
    logic        flush;
    logic        inValid;
    logic        outReady;
    logic [15:0] pc;
    logic [15:0] instr;
    logic        expValid;
    logic        expReady;
    logic [1:0]  expOcc;
    logic [15:0] expInstr;
    logic [15:0] expPcP2;
  } vec_t;
  vec_t vecs[9];

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk(clk), .rst_n(rstN), .flush(flush),
    .in_valid(inValid), .in_ready(inReady),
    .in_pc(inPc), .in_pc_plus2(inPcP2), .in_instr(inInstr),
    .out_valid(outValid), .out_ready(outReady),
    .out_pc(outPc), .out_pc_plus2(outPcP2), .out_instr(outInstr),
    .occupancy(occ)
  );

  pipe_stage_skid #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(32'h0)) dutWide (
    .clk(clk), .rst_n(rstN), .flush(wFlush),
    .in_valid(wInValid), .in_ready(wInReady),
    .in_pc(wInPc), .in_pc_plus2(wInPcP2), .in_instr(wInInstr),
    .out_valid(wOutValid), .out_ready(wOutReady),
    .out_pc(wOutPc), .out_pc_plus2(wOutPcP2), .out_instr(wOutInstr),
    .occupancy(wOcc)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic f, input logic v, input logic r,
                               input logic [15:0] pc, input logic [15:0] instr);
    flush    = f;
    inValid  = v;
    outReady = r;
    inPc     = pc;
    inPcP2   = pc + 16'd2;
    inInstr  = instr;
  endtask

  task automatic applyWide(input logic f, input logic v, input logic r,
                           input logic [31:0] pc, input logic [31:0] instr);
    wFlush    = f;
    wInValid  = v;
    wOutReady = r;
    wInPc     = pc;
    wInPcP2   = pc + 32'd2;
    wInInstr  = instr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Emits are retired before the same cycle's accept is queued; a flush drops everything still held.
  always @(negedge clk) begin
    if (rstN) begin
      if (outValid && outReady) begin
        if (sbQ.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL sb_unexpected_emit: got pc 0x%0h, expected no entry", outPc);
        end else begin
          sb_t e;
          e = sbQ.pop_front();
          checkOutput("sb_pc", {16'h0, outPc}, {16'h0, e.pc});
          checkOutput("sb_pc_plus2", {16'h0, outPcP2}, {16'h0, e.pcP2});
          checkOutput("sb_instr", {16'h0, outInstr}, {16'h0, e.instr});
          emitCount++;
        end
      end
      if (flush) sbQ.delete();
      else if (inValid && inReady) sbQ.push_back('{inPc, inPcP2, inInstr});
    end
  end

  initial begin
    vecs[0] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b0, 1'b1, 2'd0, NOP16,    16'h0000};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0010, 16'h1234, 1'b1, 1'b1, 2'd1, 16'h1234, 16'h0012};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd0, NOP16,    16'h0000};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0100, 16'hA001, 1'b1, 1'b1, 2'd1, 16'hA001, 16'h0102};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0110, 16'hB002, 1'b1, 1'b0, 2'd2, 16'hA001, 16'h0102};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0120, 16'hC003, 1'b1, 1'b0, 2'd2, 16'hA001, 16'h0102};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'h0120, 16'hC003, 1'b1, 1'b1, 2'd1, 16'hB002, 16'h0112};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 16'h0120, 16'hC003, 1'b1, 1'b1, 2'd1, 16'hC003, 16'h0122};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 2'd0, NOP16,    16'h0000};

    rstN = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    applyWide(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rstN = 1'b0;
    #1;
    checkOutput("rst_valid", {31'h0, outValid}, 32'h0);
    checkOutput("rst_ready", {31'h0, inReady}, 32'h0);
    checkOutput("rst_occ", {30'h0, occ}, 32'h0);
    checkOutput("rst_instr", {16'h0, outInstr}, {16'h0, NOP16});
    checkOutput("rst_pc", {16'h0, outPc}, 32'h0);
    checkOutput("rst_pc_plus2", {16'h0, outPcP2}, 32'h0);

    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].flush, vecs[i].inValid, vecs[i].outReady, vecs[i].pc, vecs[i].instr);
      if (i == 0) rstN = 1'b1;
      tick();
      checkOutput($sformatf("v%0d_valid", i), {31'h0, outValid}, {31'h0, vecs[i].expValid});
      checkOutput($sformatf("v%0d_ready", i), {31'h0, inReady}, {31'h0, vecs[i].expReady});
      checkOutput($sformatf("v%0d_occ", i), {30'h0, occ}, {30'h0, vecs[i].expOcc});
      checkOutput($sformatf("v%0d_instr", i), {16'h0, outInstr}, {16'h0, vecs[i].expInstr});
      checkOutput($sformatf("v%0d_pc_plus2", i), {16'h0, outPcP2}, {16'h0, vecs[i].expPcP2});
    end

    emitStart = emitCount;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 16'h0200 + 16'(2 * k), 16'h3000 + 16'(k));
      tick();
      checkOutput($sformatf("stream%0d_valid", k), {31'h0, outValid}, 32'h1);
      checkOutput($sformatf("stream%0d_occ", k), {30'h0, occ}, 32'h1);
      checkOutput($sformatf("stream%0d_ready", k), {31'h0, inReady}, 32'h1);
      checkOutput($sformatf("stream%0d_instr", k), {16'h0, outInstr}, 32'h3000 + 32'(k));
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    tick();
    checkOutput("stream_drain_valid", {31'h0, outValid}, 32'h0);
    checkOutput("stream_emits", 32'(emitCount - emitStart), 32'd8);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0300, 16'hD004);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0310, 16'hE005);
    tick();
    checkOutput("fl_full_occ", {30'h0, occ}, 32'h2);
    checkOutput("fl_full_ready", {31'h0, inReady}, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0320, 16'hF006);
    tick();
    checkOutput("fl_valid", {31'h0, outValid}, 32'h0);
    checkOutput("fl_instr", {16'h0, outInstr}, {16'h0, NOP16});
    checkOutput("fl_occ", {30'h0, occ}, 32'h0);
    checkOutput("fl_ready", {31'h0, inReady}, 32'h1);
    checkOutput("fl_pc", {16'h0, outPc}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    tick();
    checkOutput("fl_after_valid", {31'h0, outValid}, 32'h0);

    // Flush in HALF with a simultaneous emit and accept: the emit is consumed, the accept is discarded.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0400, 16'h1111);
    tick();
    applyStimulus(1'b1, 1'b1, 1'b1, 16'h0410, 16'h2222);
    tick();
    checkOutput("flh_valid", {31'h0, outValid}, 32'h0);
    checkOutput("flh_occ", {30'h0, occ}, 32'h0);
    checkOutput("flh_ready", {31'h0, inReady}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    tick();
    checkOutput("flh_after_valid", {31'h0, outValid}, 32'h0);

    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0500, 16'h3333);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0510, 16'h4444);
    tick();
    checkOutput("ar_full_occ", {30'h0, occ}, 32'h2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    @(negedge clk);
    #2 rstN = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("ar_valid", {31'h0, outValid}, 32'h0);
    checkOutput("ar_ready", {31'h0, inReady}, 32'h0);
    checkOutput("ar_occ", {30'h0, occ}, 32'h0);
    checkOutput("ar_instr", {16'h0, outInstr}, {16'h0, NOP16});
    checkOutput("ar_pc", {16'h0, outPc}, 32'h0);
    checkOutput("ar_pc_plus2", {16'h0, outPcP2}, 32'h0);
    tick();
    rstN = 1'b1;
    checkOutput("ar_rel_ready", {31'h0, inReady}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0, 16'h0);
    tick();
    checkOutput("ar_edge1_ready", {31'h0, inReady}, 32'h1);
    checkOutput("ar_edge1_valid", {31'h0, outValid}, 32'h0);
    tick();
    checkOutput("ar_edge2_valid", {31'h0, outValid}, 32'h0);

    applyWide(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFE, 32'hDEAD_BEEF);
    tick();
    checkOutput("w_valid", {31'h0, wOutValid}, 32'h1);
    checkOutput("w_pc", wOutPc, 32'hFFFF_FFFE);
    checkOutput("w_pc_plus2", wOutPcP2, 32'h0000_0000);
    checkOutput("w_instr", wOutInstr, 32'hDEAD_BEEF);
    applyWide(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    checkOutput("w_drain_valid", {31'h0, wOutValid}, 32'h0);
    checkOutput("w_drain_instr", wOutInstr, 32'h0);

    applyWide(1'b0, 1'b1, 1'b0, 32'hFFFF_0000, 32'h0BAD_F00D);
    tick();
    applyWide(1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'hCAFE_BABE);
    tick();
    checkOutput("w_full_occ", {30'h0, wOcc}, 32'h2);
    checkOutput("w_full_ready", {31'h0, wInReady}, 32'h0);
    checkOutput("w_full_instr", wOutInstr, 32'h0BAD_F00D);
    applyWide(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    checkOutput("w_second_instr", wOutInstr, 32'hCAFE_BABE);
    checkOutput("w_second_pc_plus2", wOutPcP2, 32'h8000_0002);
    tick();
    checkOutput("w_empty_valid", {31'h0, wOutValid}, 32'h0);

    applyWide(1'b0, 1'b1, 1'b0, 32'h1000_0000, 32'h1111_1111);
    tick();
    applyWide(1'b0, 1'b1, 1'b0, 32'h2000_0000, 32'h2222_2222);
    tick();
    applyWide(1'b1, 1'b1, 1'b0, 32'h3000_0000, 32'h3333_3333);
    tick();
    checkOutput("w_fl_valid", {31'h0, wOutValid}, 32'h0);
    checkOutput("w_fl_occ", {30'h0, wOcc}, 32'h0);
    checkOutput("w_fl_ready", {31'h0, wInReady}, 32'h1);
    checkOutput("w_fl_instr", wOutInstr, 32'h0);
    checkOutput("w_fl_pc", wOutPc, 32'h0);
    applyWide(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    tick();
    checkOutput("w_fl_after_valid", {31'h0, wOutValid}, 32'h0);

    checkOutput("sb_leftover", 32'(sbQ.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
